// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Brief   : Segment patterns, error codes and FSM states for the 7-seg reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0     = 7'h40;
  localparam logic [6:0] c_seg_1     = 7'h79;
  localparam logic [6:0] c_seg_2     = 7'h24;
  localparam logic [6:0] c_seg_3     = 7'h30;
  localparam logic [6:0] c_seg_4     = 7'h19;
  localparam logic [6:0] c_seg_5     = 7'h12;
  localparam logic [6:0] c_seg_6     = 7'h02;
  localparam logic [6:0] c_seg_7     = 7'h78;
  localparam logic [6:0] c_seg_8     = 7'h00;
  localparam logic [6:0] c_seg_9     = 7'h10;
  localparam logic [6:0] c_seg_blank = 7'h7F;

  localparam logic [3:0] c_nib_blank = 4'hF;

  localparam logic [1:0] c_err_none    = 2'b00;
  localparam logic [1:0] c_err_invalid = 2'b01;
  localparam logic [1:0] c_err_timeout = 2'b10;
  localparam logic [1:0] c_err_multi   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
// Module  : seg7_pattern_decode
// Brief   : Combinational active-low 7-segment pattern to BCD nibble decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_invalid
);

  always_comb begin
    o_nibble  = c_nib_blank;
    o_invalid = 1'b0;
    case (i_seg_n)
      c_seg_0:     o_nibble = 4'd0;
      c_seg_1:     o_nibble = 4'd1;
      c_seg_2:     o_nibble = 4'd2;
      c_seg_3:     o_nibble = 4'd3;
      c_seg_4:     o_nibble = 4'd4;
      c_seg_5:     o_nibble = 4'd5;
      c_seg_6:     o_nibble = 4'd6;
      c_seg_7:     o_nibble = 4'd7;
      c_seg_8:     o_nibble = 4'd8;
      c_seg_9:     o_nibble = 4'd9;
      c_seg_blank: o_nibble = c_nib_blank;
      default:     o_invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_to_bcd_reader.sv
// ============================================================================
// Module  : seg7_to_bcd_reader
// Brief   : Captures one multiplexed 4-digit 7-segment frame into packed BCD.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_n,
  input  logic        capture_req,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int c_stab_w = $clog2(STABLE_CYCLES + 1);
  localparam int c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);
  localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 1);
  localparam logic [c_stab_w-1:0] c_stab_pre  = c_stab_w'(STABLE_CYCLES - 2);
  localparam logic [c_to_w-1:0]   c_to_one    = c_to_w'(1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_next;
  logic [10:0]         r_prev;
  logic [c_stab_w-1:0] r_stab_cnt, w_stab_cnt_next;
  logic [c_stab_w-1:0] r_multi_cnt, w_multi_cnt_next;
  logic [c_to_w-1:0]   r_to_cnt, w_to_cnt_next;
  logic [3:0]          r_flags, w_flags_next;
  logic [15:0]         r_hold, w_hold_next;
  logic [15:0]         r_bcd, w_bcd_next;
  logic [1:0]          r_err, w_err_next;
  logic [3:0]          w_nibble;
  logic                w_invalid;
  logic                w_same, w_one_hot, w_multi, w_fault;
  logic [1:0]          w_dig_idx;

  seg7_pattern_decode u_decode (
    .i_seg_n   (seg_n),
    .o_nibble  (w_nibble),
    .o_invalid (w_invalid)
  );

  assign w_same    = ({dig_n, seg_n} == r_prev);
  assign w_one_hot = $onehot(~dig_n);
  assign w_multi   = ($countones(~dig_n) > 1);

  always_comb begin
    w_dig_idx = 2'd0;
    case (dig_n)
      4'b1101: w_dig_idx = 2'd1;
      4'b1011: w_dig_idx = 2'd2;
      4'b0111: w_dig_idx = 2'd3;
      default: w_dig_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_stab_cnt_next  = r_stab_cnt;
    w_multi_cnt_next = r_multi_cnt;
    w_to_cnt_next    = r_to_cnt;
    w_flags_next     = r_flags;
    w_hold_next      = r_hold;
    w_bcd_next       = r_bcd;
    w_err_next       = r_err;
    w_fault          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_req) begin
          w_state_next     = ST_CAPTURE;
          w_stab_cnt_next  = '0;
          w_multi_cnt_next = '0;
          w_to_cnt_next    = '0;
          w_flags_next     = 4'h0;
          w_err_next       = c_err_none;
        end
      end
      ST_CAPTURE: begin
        w_to_cnt_next = r_to_cnt + c_to_one;
        if (w_same && w_one_hot)
          w_stab_cnt_next = (r_stab_cnt == c_stab_last) ? r_stab_cnt : r_stab_cnt + c_stab_one;
        else
          w_stab_cnt_next = '0;
        if (w_multi)
          w_multi_cnt_next = (r_multi_cnt == c_stab_last) ? r_multi_cnt : r_multi_cnt + c_stab_one;
        else
          w_multi_cnt_next = '0;

        // Sample on the STABLE_CYCLES-th identical cycle, once per digit
        if (w_same && w_one_hot && (r_stab_cnt == c_stab_pre) && !r_flags[w_dig_idx]) begin
          if (w_invalid) begin
            w_err_next = c_err_invalid;
            w_fault    = 1'b1;
          end else begin
            w_hold_next[{w_dig_idx, 2'b00} +: 4] = w_nibble;
            w_flags_next[w_dig_idx]              = 1'b1;
          end
        end
        if (w_multi && (r_multi_cnt == c_stab_last)) begin
          w_err_next = c_err_multi;
          w_fault    = 1'b1;
        end

        // Completion wins over a coincident timeout
        if (w_fault) begin
          w_state_next = ST_IDLE;
        end else if (w_flags_next == 4'hF) begin
          w_state_next = ST_DONE;
          w_bcd_next   = w_hold_next;
        end else if (r_to_cnt == c_to_last) begin
          w_state_next = ST_IDLE;
          w_err_next   = c_err_timeout;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prev      <= 11'h7FF;
      r_stab_cnt  <= '0;
      r_multi_cnt <= '0;
      r_to_cnt    <= '0;
      r_flags     <= 4'h0;
      r_hold      <= 16'hFFFF;
      r_bcd       <= 16'hFFFF;
      r_err       <= c_err_none;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= {dig_n, seg_n};
      r_stab_cnt  <= w_stab_cnt_next;
      r_multi_cnt <= w_multi_cnt_next;
      r_to_cnt    <= w_to_cnt_next;
      r_flags     <= w_flags_next;
      r_hold      <= w_hold_next;
      r_bcd       <= w_bcd_next;
      r_err       <= w_err_next;
    end
  end

  assign bcd   = r_bcd;
  assign valid = (r_state == ST_DONE);
  assign busy  = (r_state == ST_CAPTURE);
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seg7_to_bcd_reader.sv
// ============================================================================
// Module  : tb_seg7_to_bcd_reader
// Brief   : Self-checking bench for seg7_to_bcd_reader with a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg7_to_bcd_reader;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b1;
  logic [6:0]  seg_n       = 7'h7F;
  logic [3:0]  dig_n       = 4'hF;
  logic        capture_req = 1'b0;
  logic [15:0] bcd;
  logic        valid;
  logic        busy;
  logic [1:0]  err;

  seg7_to_bcd_reader #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .capture_req (capture_req),
    .bcd         (bcd),
    .valid       (valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          valid_seen = 0;
  int          busy_seen  = 0;
  logic [15:0] exp_bcd    = 16'hFFFF;
  logic [6:0]  pat_tab [0:10];

  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (busy)  busy_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    dig_n    = 4'hF;
    dig_n[d] = 1'b0;
    seg_n    = p;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    dig_n = 4'hF;
    seg_n = 7'h7F;
    repeat (n) tick();
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    check_val("idle_within_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [6:0] p3, input logic [6:0] p2,
                           input logic [6:0] p1, input logic [6:0] p0, input int hold);
    blank(2);
    pulse_req();
    show(3, p3, hold);
    show(2, p2, hold);
    show(1, p1, hold);
    show(0, p0, hold);
    blank(4);
    wait_idle(2000);
  endtask

  function automatic bit in_table(input logic [6:0] p);
    for (int i = 0; i <= 10; i++) if (pat_tab[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int          v0;
    int          b0;
    int          vals [4];
    int          holds[4];
    logic [6:0]  pats [4];
    logic [15:0] nb;
    logic [1:0]  exp_err;
    int          exp_valid;

    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_val("rst_bcd",   {16'd0, bcd},   32'hFFFF);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_busy",  {31'd0, busy},  32'd0);
    check_val("rst_err",   {30'd0, err},   32'd0);
    rst_n = 1'b1;
    blank(2);

    // Frame 1,2,3,4 with busy latency check
    v0 = valid_seen;
    pulse_req();
    check_val("busy_after_req", {31'd0, busy}, 32'd1);
    show(3, 7'h79, 8); show(2, 7'h24, 8); show(1, 7'h30, 8); show(0, 7'h19, 8);
    blank(4);
    wait_idle(2000);
    exp_bcd = 16'h1234;
    check_val("f1234_valid", valid_seen - v0, 1);
    check_val("f1234_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});
    check_val("f1234_err",   {30'd0, err}, 32'd0);

    // Invalid pattern on digit 1
    v0 = valid_seen;
    run_frame(7'h79, 7'h24, 7'h7E, 7'h19, 8);
    check_val("inv_valid", valid_seen - v0, 0);
    check_val("inv_err",   {30'd0, err}, 32'd1);
    check_val("inv_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});
    blank(10);
    check_val("inv_err_hold", {30'd0, err}, 32'd1);

    // Blank most significant digit
    v0 = valid_seen;
    run_frame(7'h7F, 7'h40, 7'h40, 7'h78, 8);
    exp_bcd = 16'hF007;
    check_val("f007_valid", valid_seen - v0, 1);
    check_val("f007_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});
    check_val("f007_err",   {30'd0, err}, 32'd0);

    // Digit held one cycle short is not sampled; captured digits are not re-sampled
    v0 = valid_seen;
    blank(2);
    pulse_req();
    show(3, 7'h79, 8); show(2, 7'h24, 8); show(1, 7'h30, 8); show(0, 7'h10, STABLE - 1);
    show(3, 7'h00, 8); show(2, 7'h00, 8); show(1, 7'h00, 8); show(0, 7'h19, STABLE);
    blank(4);
    wait_idle(2000);
    exp_bcd = 16'h1234;
    check_val("short_valid", valid_seen - v0, 1);
    check_val("short_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});

    // Timeout, with an ignored second request mid-capture
    blank(2);
    dig_n = 4'b1110;
    seg_n = 7'h79;
    v0 = valid_seen;
    b0 = busy_seen;
    pulse_req();
    repeat (500) tick();
    pulse_req();
    wait_idle(2000);
    check_val("to_busy_cycles", busy_seen - b0, TIMEOUT);
    check_val("to_err",   {30'd0, err}, 32'd2);
    check_val("to_valid", valid_seen - v0, 0);
    check_val("to_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});

    // Two digits enabled together, second request ignored
    blank(2);
    dig_n = 4'b1100;
    seg_n = 7'h40;
    tick();
    v0 = valid_seen;
    b0 = busy_seen;
    pulse_req();
    pulse_req();
    repeat (10) tick();
    wait_idle(50);
    check_val("multi_err",   {30'd0, err}, 32'd3);
    check_val("multi_busy",  busy_seen - b0, STABLE);
    check_val("multi_valid", valid_seen - v0, 0);
    blank(10);
    check_val("multi_err_hold", {30'd0, err}, 32'd3);

    // Reset mid-capture, then a fresh frame 5,6,9,0
    blank(2);
    pulse_req();
    show(3, 7'h12, 8);
    show(2, 7'h02, 8);
    v0 = valid_seen;
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_bcd",  {16'd0, bcd},  32'hFFFF);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_err",  {30'd0, err},  32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    check_val("arst_no_valid", valid_seen - v0, 0);
    run_frame(7'h12, 7'h02, 7'h10, 7'h40, 8);
    exp_bcd = 16'h5690;
    check_val("f5690_valid", valid_seen - v0, 1);
    check_val("f5690_bcd",   {16'd0, bcd}, {16'd0, exp_bcd});

    // Randomised frames against the frame-level model
    for (int f = 0; f < 12; f++) begin
      for (int d = 0; d < 4; d++) begin
        holds[d] = $urandom_range(8, STABLE);
        if ($urandom_range(7, 0) == 0) begin
          vals[d] = -1;
          do pats[d] = 7'($urandom_range(127, 0)); while (in_table(pats[d]));
        end else begin
          vals[d] = $urandom_range(10, 0);
          pats[d] = pat_tab[vals[d]];
        end
      end
      exp_err   = 2'b00;
      exp_valid = 1;
      nb        = 16'h0000;
      for (int d = 3; d >= 0; d--) begin
        if (vals[d] < 0) begin
          exp_err   = 2'b01;
          exp_valid = 0;
          break;
        end
        nb[d*4 +: 4] = (vals[d] == 10) ? 4'hF : 4'(vals[d]);
      end
      if (exp_valid == 1) exp_bcd = nb;

      v0 = valid_seen;
      blank(2);
      pulse_req();
      for (int d = 3; d >= 0; d--) begin
        show(d, pats[d], holds[d]);
        blank($urandom_range(2, 0));
      end
      blank(4);
      wait_idle(2000);
      check_val($sformatf("rnd%0d_valid", f), valid_seen - v0, exp_valid);
      check_val($sformatf("rnd%0d_err", f),   {30'd0, err}, {30'd0, exp_err});
      check_val($sformatf("rnd%0d_bcd", f),   {16'd0, bcd}, {16'd0, exp_bcd});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_to_bcd_reader.md
SEG7_TO_BCD_READER -- requirements
Module: seg7_to_bcd_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical cycles required before a digit is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles per capture, counted from acceptance of capture_req.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port seg_n, input, 7: segment bus {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-006 SHALL have port dig_n, input, 4: digit enables, active-low; bit 3 = most significant digit.
REQ-007 SHALL have port capture_req, input, 1: single-cycle request to capture one display frame.
REQ-008 SHALL have port bcd, output, 16: captured digits, nibble 3 = digit 3; 0xF = blank digit.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when bcd is updated.
REQ-010 SHALL have port busy, output, 1: high while a capture is in progress.
REQ-011 SHALL have port err, output, 2: 00 none, 01 invalid pattern, 10 timeout, 11 multiple digits enabled.

Function
REQ-012 SHALL implement FSM IDLE -> CAPTURE -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-013 SHALL accept capture_req only in IDLE; capture_req in CAPTURE or DONE SHALL be ignored.
REQ-014 On acceptance SHALL clear the 4-bit captured-flags, the stability counter, the timeout counter and err; busy rises the following cycle.
REQ-015 In CAPTURE, the stability counter SHALL increment when {dig_n, seg_n} equals the previous cycle value and exactly one dig_n bit is low, else reset to 0.
REQ-016 When the stability counter reaches STABLE_CYCLES-1 for a digit whose flag is clear, that digit SHALL be decoded into a holding register and its flag set; already-captured digits SHALL NOT be re-sampled.
REQ-017 Decode (active-low hex) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F->F (blank); any other pattern is invalid.
REQ-018 Invalid stable pattern SHALL set err=01 and go to IDLE, bcd unchanged, no valid.
REQ-019 Two or more dig_n bits low for STABLE_CYCLES consecutive cycles SHALL set err=11 and go to IDLE; dig_n = 4'hF (inter-digit blanking) SHALL only reset the counter, never an error.
REQ-020 Timeout counter reaching TIMEOUT_CYCLES with flags incomplete SHALL set err=10 and go to IDLE, bcd unchanged.
REQ-021 When the fourth flag sets, SHALL enter DONE next cycle: bcd loads all four nibbles, valid=1, busy=0, err=00.
REQ-022 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-023 err SHALL hold until the next accepted capture_req or reset.
REQ-024 bcd SHALL hold its value between valid pulses.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, bcd=16'hFFFF, valid=0, busy=0, err=00, all counters and flags 0.
REQ-026 Reset mid-capture SHALL abandon the frame with no valid pulse; the first capture_req after release SHALL be honoured.

Structure
REQ-027 Package seg7_pkg SHALL hold the ten digit patterns and blank pattern, err codes and FSM state encodings.
REQ-028 Pattern-to-nibble decode SHALL be sub-module seg7_pattern_decode (combinational, 7-bit in, 4-bit nibble + invalid flag out).
REQ-029 Counter widths SHALL be derived from the parameters via clog2.

Verification
REQ-030 Scan digits 3..0 showing 1,2,3,4 (79,24,30,19), 8 cycles each, capture_req -> valid once, bcd=16'h1234, err=00.
REQ-031 Scan with digit 3 blank (7F) and others 0,0,7 -> bcd=16'hF007, valid pulse.
REQ-032 Digit 1 shows 7'h7E stable -> err=01, no valid, bcd holds previous 16'h1234.
REQ-033 dig_n=4'b1110 only, capture_req -> after 1024 cycles err=10, busy falls, no valid.
REQ-034 dig_n=4'b1100 held 4 cycles -> err=11; second capture_req during CAPTURE ignored (no restart of timeout).
REQ-035 rst_n pulsed low after two digits captured -> bcd=16'hFFFF, busy=0 immediately; next full frame 5,6,9,0 -> bcd=16'h5690.
